uart_rx_fifo: RTL and testbench

// - Receive buffer directly downstream of the UART receiver.
// - Captures each completed frame (rx_frame, qualified by the one-cycle rx_done

---
 rtl/uart_rx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: stores {err, frame}, FWFT read port, level/almost-full/overflow tracking.
// Optional macro UART_RX_FIFO_ERR_DROP_EN: discard frames flagged with frame_error instead of storing them.
module uart_rx_fifo #(
  parameter int unsigned DATA_WD  = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WD-1:0]         rx_frame,
  input  logic                       rx_done,
  input  logic                       frame_error,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_WD-1:0]         rd_data,
  output logic                       rd_err,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
`ifdef UART_RX_FIFO_ERR_DROP_EN
  localparam int unsigned MW = DATA_WD;
`else
  localparam int unsigned MW = DATA_WD + 1;
`endif

  logic [MW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_almost_full;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic          w_empty;
  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [MW-1:0] w_wr_word;
  logic [MW-1:0] w_head;
  logic [LW-1:0] w_level_nxt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign w_accept  = rx_done && !frame_error;
  assign w_wr_word = rx_frame;
`else
  assign w_accept  = rx_done;
  assign w_wr_word = {frame_error, rx_frame};
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_pop  = !w_empty && rd_ready;
  assign w_push = w_accept && (!w_full || w_pop);
  assign w_drop = w_accept && w_full && !w_pop;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array is not reset; the read port is gated while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level       <= w_level_nxt;
      r_almost_full <= (w_level_nxt >= LW'(AF_LEVEL));
    end
  end

  // A drop in the same cycle as ovf_clr wins and restarts the count at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (ovf_clr)                 r_drop_cnt <= 8'h01;
      else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'h01;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'h00;
    end
  end

  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign rd_valid = !w_empty;
  assign rd_data  = w_empty ? '0 : w_head[DATA_WD-1:0];
`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign rd_err   = 1'b0;
`else
  assign rd_err   = w_empty ? 1'b0 : w_head[DATA_WD];
`endif

  assign level       = r_level;
  assign almost_full = r_almost_full;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic against a queue-based reference model.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_frame;
  logic       rx_done;
  logic       frame_error;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_err;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {err, data}, sticky flag and drop count
  logic [8:0] m_q[$];
  logic       m_ovf;
  int         m_drop;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WD(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk(clk), .rst_n(rst_n), .rx_frame(rx_frame), .rx_done(rx_done),
    .frame_error(frame_error), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_err(rd_err), .level(level),
    .almost_full(almost_full), .overflow(overflow), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int lvl;
    lvl = m_q.size();
    chk("level",       32'(level),       32'(lvl));
    chk("rd_valid",    32'(rd_valid),    32'(lvl != 0));
    chk("rd_data",     32'(rd_data),     (lvl != 0) ? 32'(m_q[0][7:0]) : 32'h0);
    chk("rd_err",      32'(rd_err),      (lvl != 0) ? 32'(m_q[0][8])   : 32'h0);
    chk("almost_full", 32'(almost_full), 32'(lvl >= 12));
    chk("overflow",    32'(overflow),    32'(m_ovf));
    chk("drop_cnt",    32'(drop_cnt),    32'(m_drop));
  endtask

  // One clock cycle: drive inputs after negedge, update the model, check at next negedge
  task automatic step(input logic done, input logic [7:0] d, input logic err,
                      input logic rdy, input logic clr);
    logic pop, acc, full, drop;
    rx_done = done; rx_frame = d; frame_error = err; rd_ready = rdy; ovf_clr = clr;
    full = (m_q.size() == 16);
    pop  = rdy && (m_q.size() != 0);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    acc  = done && !err;
`else
    acc  = done;
`endif
    drop = acc && full && !pop;
    if (pop) begin
      chk("pop_data", 32'(rd_data), 32'(m_q[0][7:0]));
      void'(m_q.pop_front());
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    if (acc && !drop) m_q.push_back({err, d});
    @(posedge clk);
    @(negedge clk);
    rx_done = 1'b0; frame_error = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    check_all();
  endtask

  task automatic drain();
    while (m_q.size() != 0) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; rx_frame = 8'h00; rx_done = 1'b0; frame_error = 1'b0;
    rd_ready = 1'b0; ovf_clr = 1'b0; m_ovf = 1'b0; m_drop = 0;
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Three pushes, then in-order pops
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("three_level", 32'(level), 32'd3);
    chk("three_head",  32'(rd_data), 32'hA5);
    drain();

    // Fill, almost_full threshold, overflow drop
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("af_before_12", 32'(almost_full), 32'd0);
      if (i == 11) chk("af_at_12",     32'(almost_full), 32'd1);
    end
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set",  32'(overflow), 32'd1);
    chk("drop_one", 32'(drop_cnt), 32'd1);
    drain();

    // Full FIFO: push and pop in the same cycle must not overflow
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    chk("full_pp_level", 32'(level), 32'd16);
    chk("full_pp_drop",  32'(drop_cnt), 32'd1);
    drain();

    // Errored frame handling
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    drain();

    // Alternating push/pop across two pointer wraps
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i * 7 + 3), 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_level", 32'(level), 32'd0);

    // ovf_clr colliding with a drop, then clear alone
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
    chk("clr_drop_ovf", 32'(overflow), 32'd1);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(drop_cnt), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 260; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("drop_sat", 32'(drop_cnt), 32'hFF);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'b1 & ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0) | (i >= 1500 && i < 2000),
           ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    m_q.delete(); m_ovf = 1'b0; m_drop = 0;
    check_all();
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all();
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
